instr_ingress_arbiter: RTL and testbench

Shares the instruction buffer's single 64-bit write port between NUM_REQ host-side instruction sources (e.g. host DMA, debug port, config loader) in the external_clk domain. Round-robin arbitration with burst locking keeps each source's instruction sequence contiguous in the buffer. The block applies backpressure from the buffer's full flag and registers the write toward the buffer.

---
 rtl/ingress_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 33 +++
 rtl/instr_ingress_arbiter.sv | 118 +++++++++++
 tb/tb_instr_ingress_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ingress_pkg.sv
// Shared types and defaults for the instruction ingress arbiter.
package ingress_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StXfer
  } state_e;

  localparam int unsigned DefDataW    = 64;
  localparam int unsigned DefMaxBurst = 8;

  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or after ptr_i, wrapping.
module rr_arbiter
  import ingress_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdW = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IdW-1:0]     ptr_i,
  output logic [IdW-1:0]     winner_o,
  output logic               any_o
);

  always_comb begin
    int unsigned   sum;
    logic [IdW-1:0] idx;
    winner_o = '0;
    any_o    = 1'b0;
    sum      = 0;
    idx      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      // Explicit wrap so non-power-of-two NUM_REQ stays in range.
      sum = 32'(ptr_i) + i;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = IdW'(sum);
      if (!any_o && req_i[idx]) begin
        winner_o = idx;
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/instr_ingress_arbiter.sv
// Round-robin, burst-locked arbiter sharing the instruction buffer's single write port.
module instr_ingress_arbiter
  import ingress_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MAX_BURST = DefMaxBurst,
  localparam int unsigned IdW = id_width(NUM_REQ)
) (
  input  logic                      external_clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      buf_full,
  output logic                      buf_wr_en,
  output logic [DATA_W-1:0]         buf_wr_data,
  output logic [IdW-1:0]            grant_id,
  output logic                      busy,
  output logic [31:0]               beat_count
);

  state_e             state_q, state_d;
  logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]     grant_q, grant_d;
  logic               busy_q, busy_d;
  logic [7:0]         burst_q, burst_d;
  logic               wr_en_q;
  logic [DATA_W-1:0]  wr_data_q;
  logic [31:0]        beat_cnt_q;

  logic [IdW-1:0]     arb_winner;
  logic               arb_any;
  logic               beat;
  logic               burst_end;
  logic [DATA_W-1:0]  beat_data;

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .winner_o(arb_winner),
    .any_o   (arb_any)
  );

  always_comb begin
    beat_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IdW'(i)) beat_data = req_data[i*DATA_W +: DATA_W];
    end
  end

  assign beat      = (state_q == StXfer) && req_valid[grant_q] && !buf_full;
  // Last beat and the MAX_BURST-th beat collapse into one release.
  assign burst_end = beat && (req_last[grant_q] || (burst_q == 8'(MAX_BURST - 1)));

  always_comb begin
    state_d   = state_q;
    rr_ptr_d  = rr_ptr_q;
    grant_d   = grant_q;
    busy_d    = busy_q;
    burst_d   = burst_q;
    req_ready = '0;
    unique case (state_q)
      StIdle: begin
        if (arb_any) begin
          grant_d = arb_winner;
          busy_d  = 1'b1;
          burst_d = '0;
          state_d = StXfer;
        end
      end
      StXfer: begin
        req_ready[grant_q] = !buf_full;
        if (beat) burst_d = burst_q + 8'd1;
        if (burst_end) begin
          state_d  = StIdle;
          busy_d   = 1'b0;
          rr_ptr_d = (grant_q == IdW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge external_clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      burst_q    <= '0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      busy_q   <= busy_d;
      burst_q  <= burst_d;
      wr_en_q  <= beat;
      if (beat) begin
        wr_data_q  <= beat_data;
        beat_cnt_q <= beat_cnt_q + 32'd1;
      end
    end
  end

  assign buf_wr_en   = wr_en_q;
  assign buf_wr_data = wr_data_q;
  assign grant_id    = grant_q;
  assign busy        = busy_q;
  assign beat_count  = beat_cnt_q;

endmodule

// File: tb/tb_instr_ingress_arbiter.sv
// Directed bench for instr_ingress_arbiter with hand-computed expectations.
module tb_instr_ingress_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 64;

  logic             external_clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_last;
  logic [NR-1:0]    req_ready;
  logic             buf_full;
  logic             buf_wr_en;
  logic [DW-1:0]    buf_wr_data;
  logic [1:0]       grant_id;
  logic             busy;
  logic [31:0]      beat_count;

  int n_checks = 0;
  int n_fail   = 0;

  instr_ingress_arbiter #(
    .NUM_REQ  (NR),
    .DATA_W   (DW),
    .MAX_BURST(8)
  ) dut (
    .external_clk(external_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .buf_full    (buf_full),
    .buf_wr_en   (buf_wr_en),
    .buf_wr_data (buf_wr_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .beat_count  (beat_count)
  );

  initial external_clk = 1'b0;
  always #5 external_clk = ~external_clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge external_clk);
    #1;
  endtask

  task automatic set_data(input int idx, input logic [63:0] v);
    req_data[idx*DW +: DW] = v;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    buf_full  = 1'b0;
    tick();
    tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ready", req_ready, 0);
    check_eq("rst_wr_en", buf_wr_en, 0);
    check_eq("rst_wr_data", buf_wr_data, 0);
    check_eq("rst_grant", grant_id, 0);
    check_eq("rst_count", beat_count, 0);
    rst = 1'b0;

    // Single requester, 3-beat burst.
    req_valid = 4'b0010;
    set_data(1, 64'hA1);
    #1;
    check_eq("t1_idle_ready", req_ready, 0);
    tick();
    check_eq("t1_grant", grant_id, 1);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_ready", req_ready, 4'b0010);
    tick();
    check_eq("t1_wr_en0", buf_wr_en, 1);
    check_eq("t1_wr0", buf_wr_data, 64'hA1);
    check_eq("t1_cnt1", beat_count, 1);
    set_data(1, 64'hA2);
    tick();
    check_eq("t1_wr1", buf_wr_data, 64'hA2);
    set_data(1, 64'hA3);
    req_last[1] = 1'b1;
    tick();
    check_eq("t1_wr_en2", buf_wr_en, 1);
    check_eq("t1_wr2", buf_wr_data, 64'hA3);
    check_eq("t1_busy_end", busy, 0);
    check_eq("t1_ready_end", req_ready, 0);
    check_eq("t1_cnt3", beat_count, 3);
    req_valid = '0;
    req_last  = '0;
    tick();
    check_eq("t1_wr_en_off", buf_wr_en, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;

    // Round-robin with 1-beat bursts from all requesters.
    for (int i = 0; i < 4; i++) set_data(i, 64'(64'hB0 + i));
    req_last  = 4'b1111;
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      check_eq("t2_grant", grant_id, 64'(k % 4));
      check_eq("t2_busy", busy, 1);
      tick();
      check_eq("t2_gap_busy", busy, 0);
      check_eq("t2_wr_en", buf_wr_en, 1);
      check_eq("t2_wr", buf_wr_data, 64'(64'hB0 + (k % 4)));
    end
    req_valid = '0;
    req_last  = '0;
    tick();
    check_eq("t2_idle", busy, 0);
    check_eq("t2_cnt", beat_count, 5);

    // MAX_BURST forced release; req 0 served in between.
    req_valid = 4'b0100;
    set_data(2, 64'hC0);
    tick();
    check_eq("t3_grant2", grant_id, 2);
    check_eq("t3_ready2", req_ready, 4'b0100);
    req_valid[0] = 1'b1;
    req_last[0]  = 1'b1;
    set_data(0, 64'hD0);
    for (int b = 1; b < 8; b++) begin
      tick();
      check_eq("t3_wr_en", buf_wr_en, 1);
      check_eq("t3_wr", buf_wr_data, 64'(64'hC0 + b - 1));
      check_eq("t3_hold", req_ready, 4'b0100);
      set_data(2, 64'(64'hC0 + b));
    end
    tick();
    check_eq("t3_wr8", buf_wr_data, 64'hC7);
    check_eq("t3_forced_rel", busy, 0);
    set_data(2, 64'hC8);
    tick();
    check_eq("t3_grant0", grant_id, 0);
    check_eq("t3_ready0", req_ready, 4'b0001);
    tick();
    check_eq("t3_wr_d0", buf_wr_data, 64'hD0);
    check_eq("t3_rel0", busy, 0);
    req_valid[0] = 1'b0;
    req_last[0]  = 1'b0;
    tick();
    check_eq("t3_regrant2", grant_id, 2);
    for (int b = 1; b < 4; b++) begin
      tick();
      check_eq("t3_wr_tail", buf_wr_data, 64'(64'hC8 + b - 1));
      set_data(2, 64'(64'hC8 + b));
      if (b == 3) req_last[2] = 1'b1;
    end
    tick();
    check_eq("t3_wr_last", buf_wr_data, 64'hCB);
    check_eq("t3_busy_end", busy, 0);
    check_eq("t3_cnt", beat_count, 18);
    req_valid = '0;
    req_last  = '0;

    // buf_full for 5 cycles mid-burst.
    req_valid = 4'b0100;
    set_data(2, 64'hE0);
    tick();
    check_eq("t4_grant", grant_id, 2);
    tick();
    check_eq("t4_wr0", buf_wr_data, 64'hE0);
    set_data(2, 64'hE1);
    buf_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check_eq("t4_full_ready", req_ready, 0);
      tick();
      check_eq("t4_full_wr_en", buf_wr_en, 0);
    end
    buf_full = 1'b0;
    #1;
    check_eq("t4_ready_back", req_ready, 4'b0100);
    tick();
    check_eq("t4_wr_en1", buf_wr_en, 1);
    check_eq("t4_wr1", buf_wr_data, 64'hE1);
    set_data(2, 64'hE2);
    req_last[2] = 1'b1;
    tick();
    check_eq("t4_wr2", buf_wr_data, 64'hE2);
    check_eq("t4_busy_end", busy, 0);
    check_eq("t4_cnt", beat_count, 21);
    req_valid = '0;
    req_last  = '0;

    // Reset mid-burst after 2 beats.
    req_valid = 4'b0100;
    set_data(2, 64'hF0);
    tick();
    check_eq("t5_grant", grant_id, 2);
    tick();
    check_eq("t5_wr0", buf_wr_data, 64'hF0);
    set_data(2, 64'hF1);
    tick();
    check_eq("t5_wr1", buf_wr_data, 64'hF1);
    rst = 1'b1;
    tick();
    check_eq("t5_busy", busy, 0);
    check_eq("t5_ready", req_ready, 0);
    check_eq("t5_cnt", beat_count, 0);
    check_eq("t5_wr_en", buf_wr_en, 0);
    check_eq("t5_grant_rst", grant_id, 0);
    rst       = 1'b0;
    req_valid = 4'b1010;
    req_last  = 4'b1000;
    set_data(1, 64'h11);
    set_data(3, 64'h33);
    tick();
    check_eq("t5_ptr_from0", grant_id, 1);
    check_eq("t5_ready1", req_ready, 4'b0010);

    // Owner stalls for 4 cycles while requester 3 waits.
    tick();
    check_eq("t6_wr0", buf_wr_data, 64'h11);
    req_valid = 4'b1000;
    for (int c = 0; c < 4; c++) begin
      check_eq("t6_hold_ready", req_ready, 4'b0010);
      check_eq("t6_hold_grant", grant_id, 1);
      check_eq("t6_hold_busy", busy, 1);
      tick();
      check_eq("t6_stall_wr_en", buf_wr_en, 0);
    end
    req_valid   = 4'b1010;
    req_last[1] = 1'b1;
    set_data(1, 64'h12);
    tick();
    check_eq("t6_wr1", buf_wr_data, 64'h12);
    check_eq("t6_busy_end", busy, 0);
    check_eq("t6_cnt", beat_count, 2);
    req_valid[1] = 1'b0;
    tick();
    check_eq("t6_next_grant", grant_id, 3);
    check_eq("t6_next_ready", req_ready, 4'b1000);
    tick();
    check_eq("t6_wr3", buf_wr_data, 64'h33);
    check_eq("t6_cnt3", beat_count, 3);
    req_valid = '0;
    req_last  = '0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
